cache_port_arbiter: RTL and testbench

//  Clocked round-robin arbiter sharing the single-port data cache between NUM_REQ

---
 rtl/cache_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 26 ++
 rtl/cache_port_arbiter.sv | 106 ++++++++++
 tb/tb_cache_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache port arbiter: FSM encoding and default widths.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int DEF_N       = 32;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_NUM_REQ = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted request after 'last', with wrap.
// Kept free of arbiter-specific state so other port arbiters can reuse it.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns idx/valid; otherwise a latch is inferred.
    idx   = '0;
    valid = 1'b0;
    // Walk from the farthest offset to the nearest so the nearest requester wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[IDX_W'((int'(last) + off) % NUM_REQ)]) begin
        idx   = IDX_W'((int'(last) + off) % NUM_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one four-phase cache port between NUM_REQ
// four-phase requesters; one transaction in flight, request fields latched at grant.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          rq_req,
  input  logic [NUM_REQ-1:0]          rq_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   rq_addr,
  input  logic [NUM_REQ*N-1:0]        rq_wdata,
  output logic [NUM_REQ-1:0]          rq_ack,
  output logic [N-1:0]                rq_rdata,
  output logic                        cache_req,
  output logic                        cache_we,
  output logic [ADDR_W-1:0]           cache_addr,
  output logic [N-1:0]                cache_wdata,
  input  logic                        cache_ack,
  input  logic [N-1:0]                cache_rdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant,
  output logic                        busy
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;
  // Set once cache_ack has been observed low in ISSUE; a stale high ack is ignored until then.
  logic             seen_low;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (rq_req),
    .last  (last_grant),
    .idx   (pick),
    .valid (pick_valid)
  );

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid)             state_nxt = ISSUE;
      ISSUE:   if (cache_ack && seen_low)  state_nxt = RELEASE;
      RELEASE: if (!cache_ack)             state_nxt = RESP;
      RESP:    if (!rq_req[grant])         state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cache_req = (state == ISSUE);
    busy      = (state != IDLE);
    rq_ack    = '0;
    if (state == RESP) rq_ack[grant] = 1'b1;
  end

  // Transaction latches: fields captured at grant, read data captured at cache ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      last_grant  <= LAST_RST;
      seen_low    <= 1'b0;
      cache_we    <= 1'b0;
      cache_addr  <= '0;
      cache_wdata <= '0;
      rq_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant       <= pick;
            cache_we    <= rq_we[pick];
            cache_addr  <= rq_addr[int'(pick)*ADDR_W +: ADDR_W];
            cache_wdata <= rq_wdata[int'(pick)*N +: N];
            seen_low    <= 1'b0;
          end
        end
        ISSUE: begin
          if (!cache_ack) seen_low <= 1'b1;
          if (cache_ack && seen_low && !cache_we) rq_rdata <= cache_rdata;
        end
        RESP: begin
          if (!rq_req[grant]) last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: behavioural cache with a fixed ack delay,
// a cycle-stepped requester agent for contention/fairness, and hand-computed expectations.
module tb_cache_port_arbiter;

  localparam int N       = 32;
  localparam int ADDR_W  = 12;
  localparam int NUM_REQ = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        rq_req, rq_we, rq_ack;
  logic [NUM_REQ*ADDR_W-1:0] rq_addr;
  logic [NUM_REQ*N-1:0]      rq_wdata;
  logic [N-1:0]              rq_rdata;
  logic                      cache_req, cache_we, cache_ack;
  logic [ADDR_W-1:0]         cache_addr;
  logic [N-1:0]              cache_wdata, cache_rdata;
  logic [1:0]                grant;
  logic                      busy;

  always #5 clk = ~clk;

  cache_port_arbiter #(.N(N), .ADDR_W(ADDR_W), .NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .rq_req      (rq_req),
    .rq_we       (rq_we),
    .rq_addr     (rq_addr),
    .rq_wdata    (rq_wdata),
    .rq_ack      (rq_ack),
    .rq_rdata    (rq_rdata),
    .cache_req   (cache_req),
    .cache_we    (cache_we),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_ack   (cache_ack),
    .cache_rdata (cache_rdata),
    .grant       (grant),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cache model: either auto-responding or driven by hand for stale-ack cases.
  bit          model_en  = 1'b1;
  logic        m_ack     = 1'b0;
  logic [N-1:0] m_rdata  = '0;
  logic        man_ack   = 1'b0;
  logic [N-1:0] man_rdata = '0;
  int          ack_delay = 2;
  int          dly_cnt   = 0;
  logic        prev_req  = 1'b0;
  logic [N-1:0] mem [0:(1<<ADDR_W)-1];

  int          log_g[$];
  logic        log_we[$];
  logic [ADDR_W-1:0] log_addr[$];
  logic [N-1:0] log_wdata[$];

  assign cache_ack   = model_en ? m_ack   : man_ack;
  assign cache_rdata = model_en ? m_rdata : man_rdata;

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    forever begin
      tick();
      if (cache_req === 1'b1 && prev_req !== 1'b1) begin
        log_g.push_back(int'(grant));
        log_we.push_back(cache_we);
        log_addr.push_back(cache_addr);
        log_wdata.push_back(cache_wdata);
      end
      prev_req = cache_req;
      if (model_en) begin
        if (cache_req === 1'b1 && !m_ack) begin
          if (dly_cnt >= ack_delay) begin
            if (cache_we) mem[cache_addr] = cache_wdata;
            else          m_rdata = mem[cache_addr];
            m_ack   = 1'b1;
            dly_cnt = 0;
          end else begin
            dly_cnt++;
          end
        end else if (cache_req !== 1'b1) begin
          m_ack   = 1'b0;
          dly_cnt = 0;
        end
      end
    end
  end

  int multi_ack = 0;
  always @(negedge clk) if ($countones(rq_ack) > 1) multi_ack <= multi_ack + 1;

  // Requester agent: each port runs want[i] four-phase transactions back to back.
  int want [NUM_REQ];

  task automatic agent_step();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq_ack[i] && rq_req[i]) begin
        rq_req[i] = 1'b0;
        if (want[i] > 0) want[i]--;
      end else if (!rq_ack[i] && !rq_req[i] && want[i] > 0) begin
        rq_req[i] = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      agent_step();
      tick();
      n++;
    end while ((busy || rq_req != '0 || (want[0] + want[1] + want[2]) != 0) && n < 400);
    check("drain_done", n < 400, 1);
  endtask

  task automatic wait_ack(input int i, output int n);
    n = 0;
    while (!rq_ack[i] && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("ack%0d_wait", i), n < 50, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n, base, ma_base, exp_g;
  bit raised1;

  initial begin
    rst      = 1'b1;
    rq_req   = '0;
    rq_we    = '0;
    rq_addr  = '0;
    rq_wdata = '0;
    want     = '{0, 0, 0};
    repeat (3) tick();
    check("rst_cache_req", cache_req, 0);
    check("rst_busy", busy, 0);
    check("rst_rq_ack", rq_ack, 0);
    check("rst_grant", grant, 0);
    check("rst_cache_we", cache_we, 0);
    check("rst_cache_addr", cache_addr, 0);
    check("rst_cache_wdata", cache_wdata, 0);
    check("rst_rq_rdata", rq_rdata, 0);
    rst = 1'b0;
    tick();

    // 1: single write from requester 0
    rq_we[0] = 1'b1; rq_addr[11:0] = 12'h000; rq_wdata[31:0] = 32'h2; rq_req[0] = 1'b1;
    wait_ack(0, n);
    check("t1_latency", n, 5);
    check("t1_ack", rq_ack, 3'b001);
    check("t1_cache_req_low", cache_req, 0);
    check("t1_grant", grant, 0);
    check("t1_rdata_kept", rq_rdata, 0);
    tick(); tick();
    check("t1_ack_held", rq_ack, 3'b001);
    rq_req[0] = 1'b0;
    tick();
    check("t1_ack_drop", rq_ack, 0);
    check("t1_idle", busy, 0);
    check("t1_pulses", log_g.size(), 1);
    check("t1_we", log_we[0], 1);
    check("t1_addr", log_addr[0], 12'h000);
    check("t1_wdata", log_wdata[0], 32'h2);
    check("t1_mem", mem[0], 32'h2);

    // 2: read-back by requester 1
    rq_we[1] = 1'b0; rq_addr[23:12] = 12'h000; rq_req[1] = 1'b1;
    wait_ack(1, n);
    check("t2_ack", rq_ack, 3'b010);
    check("t2_rdata", rq_rdata, 32'h2);
    check("t2_grant", grant, 1);
    check("t2_pulses", log_g.size(), 2);
    check("t2_we", log_we[1], 0);
    rq_req[1] = 1'b0;
    tick();
    check("t2_ack_drop", rq_ack, 0);

    // 3: contention after reset -> 0,1,2
    rst = 1'b1; tick(); rst = 1'b0; tick();
    base = log_g.size(); ma_base = multi_ack;
    rq_we    = 3'b111;
    rq_addr  = {12'h002, 12'h001, 12'h000};
    rq_wdata = {32'h12, 32'h11, 32'h10};
    want     = '{1, 1, 1};
    drain();
    check("t3_pulses", log_g.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t3_grant%0d", k), log_g[base+k], k);
      check($sformatf("t3_addr%0d", k), log_addr[base+k], k);
      check($sformatf("t3_wdata%0d", k), log_wdata[base+k], 32'h10 + k);
    end

    // 4: fairness, req0/req2 continuous, req1 raised after 10 grants
    rq_addr  = {12'h102, 12'h101, 12'h100};
    rq_wdata = {32'hA2, 32'hA1, 32'hA0};
    base = log_g.size(); raised1 = 1'b0; n = 0;
    want = '{1000, 0, 1000};
    while (log_g.size() - base < 20 && n < 2000) begin
      agent_step();
      tick();
      n++;
      if (!raised1 && log_g.size() - base >= 10) begin
        want[1] = 1;
        raised1 = 1'b1;
      end
    end
    check("t4_budget", n < 2000, 1);
    want[0] = 0; want[2] = 0;
    drain();
    for (int k = 0; k < 20; k++) begin
      if (k < 11)       exp_g = (k % 2 != 0) ? 2 : 0;
      else if (k == 11) exp_g = 1;
      else              exp_g = ((k - 12) % 2 != 0) ? 0 : 2;
      check($sformatf("t4_grant%0d", k), log_g[base+k], exp_g);
    end
    check("t34_single_ack", multi_ack - ma_base, 0);

    // 5: withdrawal while in ISSUE
    rq_we = '0; rq_addr[11:0] = 12'h001; rq_req[0] = 1'b1;
    n = 0;
    while (!cache_req && n < 20) begin tick(); n++; end
    check("t5_issue", cache_req, 1);
    base = log_g.size();
    rq_req[0] = 1'b0;
    wait_ack(0, n);
    check("t5_ack_pulse", rq_ack, 3'b001);
    check("t5_rdata", rq_rdata, 32'h11);
    tick();
    check("t5_ack_gone", rq_ack, 0);
    check("t5_idle", busy, 0);
    check("t5_grant", log_g[base-1], 0);

    // 6: reset while in ISSUE, then requester 0 wins first
    model_en = 1'b0; man_ack = 1'b0;
    rq_addr[23:12] = 12'h002; rq_req[1] = 1'b1;
    tick();
    check("t6_issue", cache_req, 1);
    check("t6_grant1", grant, 1);
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_cache_req", cache_req, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ack", rq_ack, 0);
    check("t6_rst_grant", grant, 0);
    rst = 1'b0; rq_req[0] = 1'b1; model_en = 1'b1;
    tick();
    check("t6_regrant0", grant, 0);
    check("t6_reissue", cache_req, 1);
    rq_req[1] = 1'b0;
    wait_ack(0, n);
    rq_req[0] = 1'b0;
    tick();
    check("t6_idle", busy, 0);

    // 7: stale cache_ack high on entry to ISSUE
    model_en = 1'b0; man_ack = 1'b1; man_rdata = 32'hABCD;
    rq_addr[35:24] = 12'h002; rq_req[2] = 1'b1;
    tick();
    check("t7_issue", cache_req, 1);
    tick(); tick();
    check("t7_stale_ignored", cache_req, 1);
    check("t7_no_ack", rq_ack, 0);
    man_ack = 1'b0;
    tick();
    check("t7_still_issue", cache_req, 1);
    man_ack = 1'b1;
    tick();
    check("t7_release", cache_req, 0);
    check("t7_busy", busy, 1);
    man_ack = 1'b0;
    tick();
    check("t7_resp", rq_ack, 3'b100);
    check("t7_rdata", rq_rdata, 32'hABCD);
    rq_req[2] = 1'b0;
    tick();
    check("t7_ack_drop", rq_ack, 0);
    check("t7_idle", busy, 0);
    model_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
